// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a registered-output byte FIFO and shifts each byte out
// as an asynchronous UART character (start, 8 data LSB first, optional
// parity, 1 or 2 stop bits).
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (2..65535)
//   PARITY        0 none, 1 even, 2 odd
//   STOP_BITS     1 or 2
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   en          in   allows a new pop from IDLE
//   fifo_empty  in   FIFO empty flag, sampled only in IDLE
//   fifo_dout   in   FIFO read data, valid the cycle after fifo_rd
//   fifo_rd     out  one-cycle FIFO read strobe (combinational)
//   tx          out  serial line, idles high
//   busy        out  high from the pop cycle through the last stop cycle
//   frame_done  out  pulse in the final cycle of the last stop bit
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  // The pop edge out of IDLE plays the role of POP; LOAD is the cycle in
  // which fifo_dout is valid, and its edge also drives the start bit so
  // that tx falls two cycles after the pop.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] CNT_PEN  = 16'(CLKS_PER_BIT - 2);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic        stop_q;
  logic [7:0]  sh_q;
  logic        par_q;
  logic        tx_q;
  logic        busy_q;
  logic        done_q;

  logic        pop;
  logic        bit_end;
  logic        last_stop;

  // Gated by rst so the FIFO is never drained while the transmitter is held.
  assign pop       = (state_q == IDLE) && en && !fifo_empty && !rst;
  assign bit_end   = (cnt_q == CNT_LAST);
  assign last_stop = (STOP_BITS == 2) ? stop_q : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // Every bit-time transition happens on bit_end, so the wrap to zero
      // doubles as the clear on state entry.
      cnt_q  <= bit_end ? '0 : cnt_q + 16'd1;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          tx_q  <= 1'b1;
          if (pop) begin
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          sh_q    <= fifo_dout;
          par_q   <= (^fifo_dout) ^ (PARITY == 2);
          tx_q    <= 1'b0;
          cnt_q   <= '0;
          state_q <= START;
        end
        START: begin
          if (bit_end) begin
            tx_q    <= sh_q[0];
            sh_q    <= sh_q >> 1;
            bit_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_q == 3'd7) begin
              stop_q <= 1'b0;
              if (PARITY != 0) begin
                tx_q    <= par_q;
                state_q <= PAR;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              tx_q  <= sh_q[0];
              sh_q  <= sh_q >> 1;
              bit_q <= bit_q + 3'd1;
            end
          end
        end
        PAR: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            stop_q  <= 1'b0;
            state_q <= STOP;
          end
        end
        STOP: begin
          // Registered pulse: set one cycle early so it lands in the last cycle.
          if (last_stop && cnt_q == CNT_PEN) done_q <= 1'b1;
          if (bit_end) begin
            if (last_stop) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              stop_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_rd    = pop;
  assign tx         = tx_q;
  assign busy       = busy_q | pop;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4: one DUT without parity
// fed from an 8-entry FIFO model, plus even- and odd-parity DUTs.
module tb_fifo_uart_tx;

  localparam int LIMIT = 2000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic en_p = 1'b1;

  logic       rd0, rd1, rd2;
  logic       tx0, tx1, tx2;
  logic       bz0, bz1, bz2;
  logic       fd0, fd1, fd2;
  logic       emp0, emp1, emp2;
  logic [7:0] dout0 = '0, dout1 = '0, dout2 = '0;

  logic [7:0] mem [3][8];
  int np [3] = '{0, 0, 0};
  int nq [3] = '{0, 0, 0};

  int total = 0;
  int bad   = 0;
  int cyc = 0, rd_cyc = 0, pops0 = 0, fdn0 = 0, rd_empty = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(emp0), .fifo_dout(dout0),
    .fifo_rd(rd0), .tx(tx0), .busy(bz0), .frame_done(fd0));
  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .en(en_p), .fifo_empty(emp1), .fifo_dout(dout1),
    .fifo_rd(rd1), .tx(tx1), .busy(bz1), .frame_done(fd1));
  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .en(en_p), .fifo_empty(emp2), .fifo_dout(dout2),
    .fifo_rd(rd2), .tx(tx2), .busy(bz2), .frame_done(fd2));

  assign emp0 = (np[0] == nq[0]);
  assign emp1 = (np[1] == nq[1]);
  assign emp2 = (np[2] == nq[2]);

  // FIFO models: registered read data, updated on the pop edge.
  always @(posedge clk) begin
    if (rd0) begin dout0 <= mem[0][nq[0] % 8]; nq[0] <= nq[0] + 1; end
    if (rd1) begin dout1 <= mem[1][nq[1] % 8]; nq[1] <= nq[1] + 1; end
    if (rd2) begin dout2 <= mem[2][nq[2] % 8]; nq[2] <= nq[2] + 1; end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd0) begin rd_cyc <= cyc; pops0 <= pops0 + 1; end
    if ((rd0 && emp0) || (rd1 && emp1) || (rd2 && emp2)) rd_empty <= rd_empty + 1;
    if (fd0) fdn0 <= fdn0 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] b);
    mem[k][np[k] % 8] = b;
    np[k]++;
  endtask

  function automatic logic s_tx(input int w);
    case (w)
      0: return tx0;
      1: return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic s_fd(input int w);
    case (w)
      0: return fd0;
      1: return fd1;
      default: return fd2;
    endcase
  endfunction

  // Waits (bounded) for the start bit; w = high cycles seen, -1 on timeout.
  task automatic wait_start(input int which, output int w);
    w = 0;
    while (s_tx(which) !== 1'b0 && w < LIMIT) begin
      @(negedge clk);
      w++;
    end
    if (w >= LIMIT) w = -1;
  endtask

  // Called at the negedge of the first start-bit cycle; samples nb bits.
  task automatic grab(input int which, input int nb, input int drop_at,
                      output logic [11:0] bits, output logic steady,
                      output int fdcnt, output int fdpos);
    logic v;
    bits = '0; steady = 1'b1; fdcnt = 0; fdpos = -1;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < 4; c++) begin
        v = s_tx(which);
        if (c == 0) bits[b] = v;
        else if (v !== bits[b]) steady = 1'b0;
        if (s_fd(which) === 1'b1) begin fdcnt++; fdpos = b * 4 + c + 1; end
        if (b * 4 + c == drop_at) en = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic idle(input int n, output logic low);
    low = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx0 !== 1'b1) low = 1'b1;
    end
  endtask

  logic [11:0] bits;
  logic        steady, low;
  int          w, fdcnt, fdpos, p0, st;
  logic [7:0]  pbyte [2] = '{8'hA5, 8'h07};
  logic        peven [2] = '{1'b0, 1'b1};
  logic        podd  [2] = '{1'b1, 1'b0};

  initial begin
    // Reset asserted mid-cycle, then idle with an empty FIFO.
    #3 rst = 1'b1;
    #1;
    check("rst_tx", 32'(tx0), 32'd1);
    check("rst_busy", 32'(bz0), 32'd0);
    check("rst_rd", 32'(rd0), 32'd0);
    check("rst_fd", 32'(fd0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    idle(100, low);
    check("idle_tx_low", 32'(low), 32'd0);
    check("idle_pops", 32'(pops0), 32'd0);
    check("idle_fd", 32'(fdn0), 32'd0);
    check("idle_busy", 32'(bz0), 32'd0);

    // Single byte 0xA5, no parity.
    push(0, 8'hA5);
    wait_start(0, w);
    check("single_start_found", 32'(w >= 0), 32'd1);
    check("pop_to_start", 32'(cyc - rd_cyc), 32'd2);
    check("single_busy", 32'(bz0), 32'd1);
    grab(0, 10, -1, bits, steady, fdcnt, fdpos);
    check("single_bits", 32'(bits[9:0]), 32'b1_1010_0101_0);
    check("single_steady", 32'(steady), 32'd1);
    check("single_fd_count", 32'(fdcnt), 32'd1);
    check("single_fd_pos", 32'(fdpos), 32'd40);
    check("single_pops", 32'(pops0), 32'd1);
    check("single_busy_after", 32'(bz0), 32'd0);
    check("single_tx_after", 32'(tx0), 32'd1);

    // Parity: even on u1, odd on u2, 11-bit frames of 44 cycles.
    for (int i = 0; i < 2; i++) begin
      push(1, pbyte[i]);
      wait_start(1, w);
      grab(1, 11, -1, bits, steady, fdcnt, fdpos);
      check("even_frame", 32'(bits[10:0]), 32'({1'b1, peven[i], pbyte[i], 1'b0}));
      check("even_len", 32'(fdpos), 32'd44);
      push(2, pbyte[i]);
      wait_start(2, w);
      grab(2, 11, -1, bits, steady, fdcnt, fdpos);
      check("odd_frame", 32'(bits[10:0]), 32'({1'b1, podd[i], pbyte[i], 1'b0}));
      check("odd_len", 32'(fdpos), 32'd44);
    end

    // Back-to-back drain of 8 bytes.
    p0 = pops0;
    for (int i = 0; i < 8; i++) push(0, 8'(i));
    for (int i = 0; i < 8; i++) begin
      wait_start(0, w);
      if (i > 0) check("drain_gap", 32'(w), 32'd2);
      grab(0, 10, -1, bits, steady, fdcnt, fdpos);
      check("drain_byte", 32'(bits[9:0]), 32'({1'b1, 8'(i), 1'b0}));
      check("drain_fd_pos", 32'(fdpos), 32'd40);
    end
    check("drain_pops", 32'(pops0 - p0), 32'd8);
    check("drain_empty", 32'(emp0), 32'd1);
    idle(20, low);
    check("drain_no_9th", 32'(pops0 - p0), 32'd8);
    check("drain_tx_idle", 32'(low), 32'd0);

    // en dropped during DATA of byte 1 with 3 bytes queued.
    p0 = pops0;
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    wait_start(0, w);
    grab(0, 10, 12, bits, steady, fdcnt, fdpos);
    check("en_byte1", 32'(bits[9:0]), 32'({1'b1, 8'h11, 1'b0}));
    check("en_byte1_fd", 32'(fdpos), 32'd40);
    idle(20, low);
    check("en_off_pops", 32'(pops0 - p0), 32'd1);
    check("en_off_tx", 32'(low), 32'd0);
    check("en_off_busy", 32'(bz0), 32'd0);
    en = 1'b1;
    #1;
    check("en_reassert_rd", 32'(rd0), 32'd1);
    wait_start(0, w);
    grab(0, 10, -1, bits, steady, fdcnt, fdpos);
    check("en_byte2", 32'(bits[9:0]), 32'({1'b1, 8'h22, 1'b0}));
    wait_start(0, w);
    check("en_gap", 32'(w), 32'd2);
    grab(0, 10, -1, bits, steady, fdcnt, fdpos);
    check("en_byte3", 32'(bits[9:0]), 32'({1'b1, 8'h33, 1'b0}));
    check("en_pops", 32'(pops0 - p0), 32'd3);

    // Reset during data bit 3 of 0x55; 0x3C follows, 0x55 is lost.
    p0 = pops0;
    push(0, 8'h55);
    push(0, 8'h3C);
    wait_start(0, w);
    st = 0;
    while (st < 18) begin @(negedge clk); st++; end
    check("mid_bit3", 32'(tx0), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_tx", 32'(tx0), 32'd1);
    check("mid_rst_busy", 32'(bz0), 32'd0);
    check("mid_rst_rd", 32'(rd0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_start(0, w);
    grab(0, 10, -1, bits, steady, fdcnt, fdpos);
    check("mid_next_byte", 32'(bits[9:0]), 32'({1'b1, 8'h3C, 1'b0}));
    idle(30, low);
    check("mid_pops", 32'(pops0 - p0), 32'd2);
    check("mid_no_resend", 32'(low), 32'd0);
    check("mid_empty", 32'(emp0), 32'd1);
    check("rd_never_on_empty", 32'(rd_empty), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
